jtcastle_page_dec: RTL and testbench

//  Parametrised page-latch and chip-select generator for the CPU memory map.

---
 rtl/jtcastle_pkg.sv | 20 ++
 rtl/jtcastle_page_dec_if.sv | 29 ++
 rtl/jtcastle_page_wait.sv | 69 ++++++
 rtl/jtcastle_page_dec.sv | 91 +++++++++
 tb/tb_jtcastle_page_dec.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/jtcastle_pkg.sv
// Shared types and helpers for the paged chip-select decoder.
package jtcastle_pkg;

   localparam int WAIT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } pg_state_e;

   // One-hot page select; empty when the page has no matching output.
   function automatic logic [255:0] onehot(input logic [7:0] pan, input int nsel);
      logic [255:0] v;
      v = '0;
      if (int'(pan) < nsel) v[pan] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/jtcastle_page_dec_if.sv
// CPU-side bus of the page decoder: strobes, address, data and decoded outputs.
interface jtcastle_page_dec_if #(
   parameter int PW   = 3,
   parameter int NSEL = 8,
   parameter int AW   = 16
);
   logic            cen;
   logic [AW-1:0]   addr;
   logic [7:0]      cpu_dout;
   logic            wr_n;
   logic            rd_n;
   logic            latch_cs;
   logic            rom_ok;
   logic [PW-1:0]   pan;
   logic [NSEL-1:0] sel;
   logic            rom_cs;
   logic            cpu_wait_n;
   logic            pg_err;

   modport master (
      output cen, addr, cpu_dout, wr_n, rd_n, latch_cs, rom_ok,
      input  pan, sel, rom_cs, cpu_wait_n, pg_err
   );

   modport slave (
      input  cen, addr, cpu_dout, wr_n, rd_n, latch_cs, rom_ok,
      output pan, sel, rom_cs, cpu_wait_n, pg_err
   );
endinterface

// File: rtl/jtcastle_page_wait.sv
// ROM access sequencer: holds the CPU from a window read until the minimum
// wait count has elapsed and the ROM has reported valid data.
module jtcastle_page_wait
   import jtcastle_pkg::*;
#(
   parameter int WAITS = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic cen_i,
   input  logic win_i,
   input  logic rd_n_i,
   input  logic rom_ok_i,
   output logic idle_o,
   output logic req_o,
   output logic cpu_wait_n_o
);

   pg_state_e         state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic              ok_q, ok_d;
   logic              ok_now;

   // rom_ok may arrive between CPU enables, so it is folded in every clock.
   assign ok_now = ok_q | rom_ok_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ok_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cen_i && win_i && !rd_n_i) begin
               state_d = REQ;
               cnt_d   = WAIT_W'(WAITS);
            end
         end
         REQ: begin
            ok_d = ok_now;
            if (cen_i) begin
               if (rd_n_i)                       state_d = IDLE;
               else if (cnt_q == '0 && ok_now)   state_d = DONE;
               if (cnt_q != '0) cnt_d = cnt_q - WAIT_W'(1);
            end
         end
         DONE: begin
            if (cen_i && rd_n_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ok_q    <= ok_d;
      end
   end

   assign idle_o       = (state_q == IDLE);
   assign req_o        = (state_q == REQ);
   assign cpu_wait_n_o = (state_q != REQ);

endmodule

// File: rtl/jtcastle_page_dec.sv
// Page latch and registered chip-select decode for the paged CPU window,
// with ROM request/wait handling delegated to jtcastle_page_wait.
module jtcastle_page_dec
   import jtcastle_pkg::*;
#(
   parameter int            PW     = 3,
   parameter int            NSEL   = 8,
   parameter int            AW     = 16,
   parameter logic [AW-1:0] WBASE  = 16'h6000,
   parameter logic [AW-1:0] WMASK  = 16'he000,
   parameter int            WAITS  = 2,
   parameter bit            ACT_LO = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   jtcastle_page_dec_if.slave  bus
);

   logic [PW-1:0]   pan_q, pan_d;
   logic [PW-1:0]   pend_val_q, pend_val_d;
   logic            pend_vld_q, pend_vld_d;
   logic [NSEL-1:0] sel_q, sel_d;
   logic            pg_err_q, pg_err_d;
   logic            win, latch_wr, idle, req;
   logic [255:0]    oh;
   logic            unused_bits;

   assign win      = ((bus.addr & WMASK) == WBASE) && (!bus.rd_n || !bus.wr_n);
   assign latch_wr = bus.latch_cs && !bus.wr_n;

   // Page writes during an access are deferred so the active select stays stable.
   always_comb begin
      pan_d      = pan_q;
      pend_val_d = pend_val_q;
      pend_vld_d = pend_vld_q;
      if (latch_wr) begin
         if (idle) begin
            pan_d      = bus.cpu_dout[PW-1:0];
            pend_vld_d = 1'b0;
         end else begin
            pend_val_d = bus.cpu_dout[PW-1:0];
            pend_vld_d = 1'b1;
         end
      end else if (pend_vld_q && idle) begin
         pan_d      = pend_val_q;
         pend_vld_d = 1'b0;
      end
   end

   always_comb begin
      oh       = onehot(8'(pan_q), NSEL);
      sel_d    = win ? oh[NSEL-1:0] : '0;
      pg_err_d = win && (int'(pan_q) >= NSEL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pan_q      <= '0;
         pend_val_q <= '0;
         pend_vld_q <= 1'b0;
         sel_q      <= '0;
         pg_err_q   <= 1'b0;
      end else if (bus.cen) begin
         pan_q      <= pan_d;
         pend_val_q <= pend_val_d;
         pend_vld_q <= pend_vld_d;
         sel_q      <= sel_d;
         pg_err_q   <= pg_err_d;
      end
   end

   jtcastle_page_wait #(.WAITS(WAITS)) u_wait (
      .clk          (clk),
      .rst          (rst),
      .cen_i        (bus.cen),
      .win_i        (win),
      .rd_n_i       (bus.rd_n),
      .rom_ok_i     (bus.rom_ok),
      .idle_o       (idle),
      .req_o        (req),
      .cpu_wait_n_o (bus.cpu_wait_n)
   );

   assign bus.pan    = pan_q;
   assign bus.sel    = ACT_LO ? ~sel_q : sel_q;
   assign bus.rom_cs = ACT_LO ? ~req : req;
   assign bus.pg_err = pg_err_q;

   assign unused_bits = ^{bus.cpu_dout, oh};

endmodule

// File: tb/tb_jtcastle_page_dec.sv
// Directed bench for jtcastle_page_dec: an 8-select instance and a 6-select
// instance with no wait states, both active-low.
module tb_jtcastle_page_dec;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   jtcastle_page_dec_if #(.PW(3), .NSEL(8), .AW(16)) ia ();
   jtcastle_page_dec_if #(.PW(3), .NSEL(6), .AW(16)) ib ();

   jtcastle_page_dec #(
      .PW(3), .NSEL(8), .AW(16), .WBASE(16'h6000), .WMASK(16'he000),
      .WAITS(2), .ACT_LO(1'b1)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ia)
   );

   jtcastle_page_dec #(
      .PW(3), .NSEL(6), .AW(16), .WBASE(16'h6000), .WMASK(16'he000),
      .WAITS(0), .ACT_LO(1'b1)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ib)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One CPU cycle: cen high for one clock, low for the next.
   task automatic cyc();
      ia.cen = 1'b1;
      ib.cen = 1'b1;
      @(posedge clk); #1;
      ia.cen = 1'b0;
      ib.cen = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      ia.cen = 1'b0; ia.addr = '0; ia.cpu_dout = '0; ia.wr_n = 1'b1;
      ia.rd_n = 1'b1; ia.latch_cs = 1'b0; ia.rom_ok = 1'b0;
      ib.cen = 1'b0; ib.addr = '0; ib.cpu_dout = '0; ib.wr_n = 1'b1;
      ib.rd_n = 1'b1; ib.latch_cs = 1'b0; ib.rom_ok = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pan",    32'(ia.pan), 32'h0);
      chk("rst_sel",    32'(ia.sel), 32'hff);
      chk("rst_romcs",  32'(ia.rom_cs), 32'h1);
      chk("rst_wait",   32'(ia.cpu_wait_n), 32'h1);
      chk("rst_pgerr",  32'(ia.pg_err), 32'h0);
      chk("rst_b_sel",  32'(ib.sel), 32'h3f);
      rst = 1'b0;

      ia.latch_cs = 1'b1; ia.wr_n = 1'b0; ia.cpu_dout = 8'h05;
      cyc();
      ia.latch_cs = 1'b0; ia.wr_n = 1'b1;
      chk("latch5_pan", 32'(ia.pan), 32'h5);
      chk("latch5_sel", 32'(ia.sel), 32'hff);

      ia.addr = 16'h6123; ia.rd_n = 1'b0;
      cyc();
      chk("rd_sel",     32'(ia.sel), 32'hdf);
      chk("rd_pan",     32'(ia.pan), 32'h5);
      chk("rd_romcs",   32'(ia.rom_cs), 32'h0);
      chk("rd_wait0",   32'(ia.cpu_wait_n), 32'h0);
      chk("rd_pgerr",   32'(ia.pg_err), 32'h0);
      cyc();
      chk("rd_wait1",   32'(ia.cpu_wait_n), 32'h0);
      cyc();
      chk("rd_wait2",   32'(ia.cpu_wait_n), 32'h0);
      cyc();
      chk("rd_wait3",   32'(ia.cpu_wait_n), 32'h0);

      // Page write during REQ, rom_ok pulsed only on a clock without cen.
      ia.latch_cs = 1'b1; ia.wr_n = 1'b0; ia.cpu_dout = 8'h03;
      ia.cen = 1'b1; ib.cen = 1'b1;
      @(posedge clk); #1;
      ia.cen = 1'b0; ib.cen = 1'b0;
      ia.latch_cs = 1'b0; ia.wr_n = 1'b1; ia.rom_ok = 1'b1;
      @(posedge clk); #1;
      ia.rom_ok = 1'b0;
      chk("rd_wait4",   32'(ia.cpu_wait_n), 32'h0);
      chk("rd_romcs4",  32'(ia.rom_cs), 32'h0);
      chk("pend_hold",  32'(ia.pan), 32'h5);
      cyc();
      chk("done_wait",  32'(ia.cpu_wait_n), 32'h1);
      chk("done_romcs", 32'(ia.rom_cs), 32'h1);
      chk("done_pan",   32'(ia.pan), 32'h5);

      ia.rd_n = 1'b1; ia.addr = 16'h0000;
      cyc();
      chk("leave_pan",  32'(ia.pan), 32'h5);
      chk("leave_sel",  32'(ia.sel), 32'hff);
      cyc();
      chk("pend_apply", 32'(ia.pan), 32'h3);

      ia.addr = 16'h6000; ia.wr_n = 1'b0;
      cyc();
      ia.wr_n = 1'b1;
      chk("wwin_romcs", 32'(ia.rom_cs), 32'h1);
      chk("wwin_wait",  32'(ia.cpu_wait_n), 32'h1);
      chk("wwin_sel",   32'(ia.sel), 32'hf7);

      ia.addr = 16'h6010; ia.rd_n = 1'b0;
      cyc();
      chk("ab_wait0",   32'(ia.cpu_wait_n), 32'h0);
      chk("ab_sel",     32'(ia.sel), 32'hf7);
      ia.rd_n = 1'b1;
      cyc();
      chk("ab_wait1",   32'(ia.cpu_wait_n), 32'h1);
      chk("ab_romcs",   32'(ia.rom_cs), 32'h1);
      chk("ab_sel_off", 32'(ia.sel), 32'hff);

      // Immediate re-read lands in REQ only if the abort went to IDLE.
      ia.rom_ok = 1'b1; ia.rd_n = 1'b0;
      cyc();
      chk("ok_pre_w0",  32'(ia.cpu_wait_n), 32'h0);
      cyc();
      chk("ok_pre_w1",  32'(ia.cpu_wait_n), 32'h0);
      cyc();
      chk("ok_pre_w2",  32'(ia.cpu_wait_n), 32'h0);
      cyc();
      chk("ok_pre_w3",  32'(ia.cpu_wait_n), 32'h1);
      ia.rom_ok = 1'b0; ia.rd_n = 1'b1;
      cyc();

      ia.addr = 16'h6000; ia.rd_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("nocen_wait", 32'(ia.cpu_wait_n), 32'h1);
      cyc();
      chk("req2_wait",  32'(ia.cpu_wait_n), 32'h0);
      ia.latch_cs = 1'b1; ia.wr_n = 1'b0; ia.cpu_dout = 8'h06;
      cyc();
      ia.latch_cs = 1'b0; ia.wr_n = 1'b1;
      chk("req2_pan",   32'(ia.pan), 32'h3);
      chk("req2_wait1", 32'(ia.cpu_wait_n), 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mrst_wait",  32'(ia.cpu_wait_n), 32'h1);
      chk("mrst_romcs", 32'(ia.rom_cs), 32'h1);
      chk("mrst_pan",   32'(ia.pan), 32'h0);
      chk("mrst_sel",   32'(ia.sel), 32'hff);
      rst = 1'b0; ia.rd_n = 1'b1; ia.addr = 16'h0000;
      cyc();
      cyc();
      chk("mrst_nopend", 32'(ia.pan), 32'h0);

      ib.latch_cs = 1'b1; ib.wr_n = 1'b0; ib.cpu_dout = 8'h07;
      cyc();
      ib.latch_cs = 1'b0; ib.wr_n = 1'b1;
      chk("b_pan7",     32'(ib.pan), 32'h7);
      chk("b_pgerr_nw", 32'(ib.pg_err), 32'h0);
      ib.addr = 16'h6000; ib.rd_n = 1'b0;
      cyc();
      chk("b_sel7",     32'(ib.sel), 32'h3f);
      chk("b_pgerr",    32'(ib.pg_err), 32'h1);
      chk("b_wait0",    32'(ib.cpu_wait_n), 32'h0);
      ib.rom_ok = 1'b1;
      cyc();
      chk("b_nowaits",  32'(ib.cpu_wait_n), 32'h1);
      ib.rom_ok = 1'b0; ib.rd_n = 1'b1;
      cyc();
      chk("b_pgerr_off", 32'(ib.pg_err), 32'h0);
      ib.addr = 16'h0000; ib.latch_cs = 1'b1; ib.wr_n = 1'b0; ib.cpu_dout = 8'h05;
      cyc();
      ib.latch_cs = 1'b0; ib.wr_n = 1'b1;
      ib.addr = 16'h6000; ib.rd_n = 1'b0;
      cyc();
      chk("b_sel5",     32'(ib.sel), 32'h1f);
      chk("b_pgerr5",   32'(ib.pg_err), 32'h0);
      chk("a_pgerr_nv", 32'(ia.pg_err), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
